venus_pipeline_top: RTL and testbench

- Top level of a minimal 3-stage in-order 32-bit core: instruction fetch → decode/issue → execute/writeback.
- Contains an internal instruction ROM, a 4×32-bit register file with per-register write-reservation (scoreboard) bits, and valid/stall handshakes between stages.
- No data ports; verification observes the required internal signals listed below by hierarchical reference.

---
 rtl/venus_pipeline_top.sv | 272 +++++++++++++++++++++++++++
 tb/tb_venus_pipeline_top.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/venus_pipeline_top.sv
// venus_pipeline_top: minimal 3-stage in-order 32-bit core (fetch, decode/issue, execute/writeback)
// with an internal instruction ROM and a 4x32 register file carrying per-register write reservations.

module venus_insnfetch #(
  parameter int                         IMEM_DEPTH = 16,
  parameter bit                         USE_IMAGE  = 1'b0,
  parameter logic [IMEM_DEPTH*32-1:0]   IMEM_PROG  = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic [31:0] insn_o
);
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] addr;

  // Built-in program: LI r0,1 / LI r1,2 / ADD r0,r1 / ADD r1,r0, remaining words NOP.
  function automatic logic [31:0] default_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (a == AW'(0)) w = 32'h1000_0001;
    if (a == AW'(1)) w = 32'h1400_0002;
    if (a == AW'(2)) w = 32'h2100_0000;
    if (a == AW'(3)) w = 32'h2400_0000;
    return w;
  endfunction

  assign addr   = addr_q;
  assign addr_d = stall_i ? addr_q : addr_q + AW'(1);

  always_comb begin
    insn_o = default_word(addr_q);
    if (USE_IMAGE) insn_o = IMEM_PROG[{addr_q, 5'd0} +: 32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end
endmodule

module venus_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_i,
  input  logic        wb_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] data_o,
  output logic        w_reserve_o
);
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic [31:0] data;
  logic        w_reserve_q;
  logic        w_reserve_d;
  logic        w_reserve;

  assign data_d = wb_i ? wb_data_i : data_q;
  // A new reservation on the same edge as the writeback clear must survive.
  assign w_reserve_d = set_i | (w_reserve_q & ~wb_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q      <= 32'h0;
      w_reserve_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      w_reserve_q <= w_reserve_d;
    end
  end

  assign data        = data_q;
  assign w_reserve   = w_reserve_q;
  assign data_o      = data;
  assign w_reserve_o = w_reserve;
endmodule

module venus_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rd_sel_i,
  input  logic [1:0]  rs_sel_i,
  input  logic        set_i,
  input  logic        wb_valid_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] rs_data_o,
  output logic [3:0]  rd_exp_o,
  output logic [3:0]  rs_exp_o,
  output logic [3:0]  wb_exp_o,
  output logic [3:0]  w_reserve_o
);
  logic [3:0]  rd_exp;
  logic [3:0]  rs_exp;
  logic [3:0]  wb_exp;
  logic [3:0]  w_reserve;
  logic [3:0]  set_exp;
  logic [31:0] wb_r;
  logic [31:0] r_data [4];

  assign rd_exp  = 4'b0001 << rd_sel_i;
  assign rs_exp  = 4'b0001 << rs_sel_i;
  assign wb_exp  = wb_valid_i ? (4'b0001 << wb_sel_i) : 4'b0000;
  assign set_exp = set_i ? rd_exp : 4'b0000;
  assign wb_r    = wb_data_i;

  venus_reg r0 (.clk(clk), .rst(rst), .set_i(set_exp[0]), .wb_i(wb_exp[0]), .wb_data_i(wb_r),
                .data_o(r_data[0]), .w_reserve_o(w_reserve[0]));
  venus_reg r1 (.clk(clk), .rst(rst), .set_i(set_exp[1]), .wb_i(wb_exp[1]), .wb_data_i(wb_r),
                .data_o(r_data[1]), .w_reserve_o(w_reserve[1]));
  venus_reg r2 (.clk(clk), .rst(rst), .set_i(set_exp[2]), .wb_i(wb_exp[2]), .wb_data_i(wb_r),
                .data_o(r_data[2]), .w_reserve_o(w_reserve[2]));
  venus_reg r3 (.clk(clk), .rst(rst), .set_i(set_exp[3]), .wb_i(wb_exp[3]), .wb_data_i(wb_r),
                .data_o(r_data[3]), .w_reserve_o(w_reserve[3]));

  assign rd_data_o   = r_data[rd_sel_i];
  assign rs_data_o   = r_data[rs_sel_i];
  assign rd_exp_o    = rd_exp;
  assign rs_exp_o    = rs_exp;
  assign wb_exp_o    = wb_exp;
  assign w_reserve_o = w_reserve;
endmodule

module venus_pipeline_top #(
  parameter int                       IMEM_DEPTH = 16,
  // Empty selects the built-in program; any other name selects the image passed in IMEM_PROG.
  parameter string                    IMEM_INIT  = "",
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_PROG  = '0
) (
  input logic clk,
  input logic rst
);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LI   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam bit         USE_IMAGE = (IMEM_INIT != "");

  logic [31:0] insn;
  logic        stall_insnfetch;
  logic        stall_insndec_insnfetch;
  logic        stall_exec_insndec;
  logic        valid_insnfetch_insndec;
  logic        valid_insndec_exec;
  logic [3:0]  wb_reserved;
  logic [31:0] data_o;

  logic [31:0] dec_insn_q, dec_insn_d;
  logic        valid_fd_q, valid_fd_d;
  logic        valid_de_q, valid_de_d;
  logic [3:0]  ex_op_q, ex_op_d;
  logic [1:0]  ex_rd_q, ex_rd_d;
  logic [31:0] ex_a_q, ex_a_d;
  logic [31:0] ex_b_q, ex_b_d;
  logic [31:0] ex_imm_q, ex_imm_d;

  logic [3:0]  dec_op;
  logic [1:0]  dec_rd;
  logic [1:0]  dec_rs;
  logic [31:0] dec_imm;
  logic        need_rd, need_rs, dec_writes, ex_writes, issue;
  logic [3:0]  rd_exp, rs_exp, wb_exp, w_reserve;
  logic [31:0] rd_data, rs_data;
  logic        unused_dec_bits;

  function automatic logic is_write(input logic [3:0] op);
    return (op == OP_LI) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MOV) || (op == OP_ADDI);
  endfunction

  venus_insnfetch #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .USE_IMAGE (USE_IMAGE),
    .IMEM_PROG (IMEM_PROG)
  ) insnfetch (
    .clk    (clk),
    .rst    (rst),
    .stall_i(stall_insnfetch),
    .insn_o (insn)
  );

  assign dec_op          = dec_insn_q[31:28];
  assign dec_rd          = dec_insn_q[27:26];
  assign dec_rs          = dec_insn_q[25:24];
  assign dec_imm         = {{16{dec_insn_q[15]}}, dec_insn_q[15:0]};
  assign unused_dec_bits = ^dec_insn_q[23:16];

  assign need_rd    = (dec_op == OP_ADD) || (dec_op == OP_SUB) || (dec_op == OP_ADDI);
  assign need_rs    = (dec_op == OP_ADD) || (dec_op == OP_SUB) || (dec_op == OP_MOV);
  assign dec_writes = is_write(dec_op);
  assign ex_writes  = valid_de_q & is_write(ex_op_q);

  // No forwarding: hold decode until every source it reads has been written back.
  assign stall_exec_insndec      = valid_fd_q & ((need_rd & |(rd_exp & w_reserve)) |
                                                 (need_rs & |(rs_exp & w_reserve)));
  assign stall_insndec_insnfetch = stall_exec_insndec;
  assign stall_insnfetch         = stall_insndec_insnfetch;
  assign issue                   = valid_fd_q & ~stall_exec_insndec;

  venus_regfile register (
    .clk        (clk),
    .rst        (rst),
    .rd_sel_i   (dec_rd),
    .rs_sel_i   (dec_rs),
    .set_i      (issue & dec_writes),
    .wb_valid_i (ex_writes),
    .wb_sel_i   (ex_rd_q),
    .wb_data_i  (data_o),
    .rd_data_o  (rd_data),
    .rs_data_o  (rs_data),
    .rd_exp_o   (rd_exp),
    .rs_exp_o   (rs_exp),
    .wb_exp_o   (wb_exp),
    .w_reserve_o(w_reserve)
  );

  always_comb begin
    data_o = 32'h0;
    case (ex_op_q)
      OP_LI:   data_o = ex_imm_q;
      OP_ADD:  data_o = ex_a_q + ex_b_q;
      OP_SUB:  data_o = ex_a_q - ex_b_q;
      OP_MOV:  data_o = ex_b_q;
      OP_ADDI: data_o = ex_a_q + ex_imm_q;
      default: data_o = 32'h0;
    endcase
  end

  assign wb_reserved = wb_exp;

  assign dec_insn_d = stall_insnfetch ? dec_insn_q : insn;
  assign valid_fd_d = stall_insnfetch ? valid_fd_q : 1'b1;
  assign valid_de_d = issue;

  // Non-writing opcodes are latched too, so a stale writer can never retire twice.
  assign ex_op_d  = issue ? dec_op  : ex_op_q;
  assign ex_rd_d  = issue ? dec_rd  : ex_rd_q;
  assign ex_a_d   = issue ? rd_data : ex_a_q;
  assign ex_b_d   = issue ? rs_data : ex_b_q;
  assign ex_imm_d = issue ? dec_imm : ex_imm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_insn_q <= 32'h0;
      valid_fd_q <= 1'b0;
      valid_de_q <= 1'b0;
      ex_op_q    <= OP_NOP;
      ex_rd_q    <= 2'd0;
      ex_a_q     <= 32'h0;
      ex_b_q     <= 32'h0;
      ex_imm_q   <= 32'h0;
    end else begin
      dec_insn_q <= dec_insn_d;
      valid_fd_q <= valid_fd_d;
      valid_de_q <= valid_de_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
    end
  end

  assign valid_insnfetch_insndec = valid_fd_q;
  assign valid_insndec_exec      = valid_de_q;
endmodule

// File: tb/tb_venus_pipeline_top.sv
// Bench for venus_pipeline_top: two cores (built-in program and a custom image) compared every cycle
// against an instruction-level schedule model; random run lengths and asynchronous mid-run resets.

module tb_venus_pipeline_top;
  localparam int MAXN = 128;
  localparam logic [511:0] PROG2 = {
    32'h5800_0001, 32'hF000_0000, 32'h2E00_0000, 32'h4900_0000,
    32'h3700_0000, 32'h1C00_8000, 32'h2000_0000, 32'h1000_7FFF,
    32'h7400_0000, 32'h5400_FFFE, 32'h0000_0000, 32'h4200_0000,
    32'h3B00_0000, 32'h5C00_0003, 32'h1C00_0005, 32'h1800_FFFF};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  venus_pipeline_top dut (.clk(clk), .rst(rst));
  venus_pipeline_top #(.IMEM_DEPTH(16), .IMEM_INIT("indep"), .IMEM_PROG(PROG2)) dut2 (.clk(clk), .rst(rst));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog    [2][16];
  logic [31:0] m_reg   [2][MAXN+1][4];
  logic [3:0]  m_wres  [2][MAXN+1];
  logic [31:0] m_val   [2][MAXN+1];
  logic [1:0]  m_rd    [2][MAXN+1];
  bit          m_issue [2][MAXN+2];
  int          m_addr  [2][MAXN+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: each instruction issues one edge after its predecessor, or two edges
  // after the issue of the last writer of any register it reads, whichever is later; it writes back
  // one edge after issue. Values come from plain sequential execution of the program.
  task automatic build_model(input int m);
    logic [31:0] arch [4];
    logic [31:0] cur [4];
    int          lw [4];
    int          e, e_prev, cnt;
    logic [31:0] w, imm, v;
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    bit          wr;
    for (int n = 0; n <= MAXN + 1; n++) m_issue[m][n] = 0;
    for (int n = 0; n <= MAXN; n++) begin
      m_wres[m][n] = 4'd0; m_val[m][n] = 32'd0; m_rd[m][n] = 2'd0;
    end
    for (int i = 0; i < 4; i++) begin arch[i] = 32'd0; cur[i] = 32'd0; lw[i] = -100; end
    e_prev = 1;
    for (int k = 0; k < 4 * MAXN; k++) begin
      w   = prog[m][k % 16];
      op  = w[31:28]; rd = w[27:26]; rs = w[25:24];
      imm = {{16{w[15]}}, w[15:0]};
      e   = e_prev + 1;
      if ((op == 4'd2 || op == 4'd3 || op == 4'd5) && lw[rd] + 2 > e) e = lw[rd] + 2;
      if ((op == 4'd2 || op == 4'd3 || op == 4'd4) && lw[rs] + 2 > e) e = lw[rs] + 2;
      if (e > MAXN) break;
      wr = 1'b1;
      case (op)
        4'd1:    v = imm;
        4'd2:    v = arch[rd] + arch[rs];
        4'd3:    v = arch[rd] - arch[rs];
        4'd4:    v = arch[rs];
        4'd5:    v = arch[rd] + imm;
        default: begin wr = 1'b0; v = 32'd0; end
      endcase
      m_issue[m][e] = 1;
      if (wr) begin
        arch[rd] = v; lw[rd] = e;
        m_wres[m][e] = 4'b0001 << rd; m_val[m][e] = v; m_rd[m][e] = rd;
      end
      e_prev = e;
    end
    cnt = 0;
    for (int n = 0; n <= MAXN; n++) begin
      if (n >= 1) begin
        cnt += int'(m_issue[m][n]);
        if (m_wres[m][n-1] != 4'd0) cur[m_rd[m][n-1]] = m_val[m][n-1];
      end
      for (int i = 0; i < 4; i++) m_reg[m][n][i] = cur[i];
      m_addr[m][n] = (n == 0) ? 0 : ((cnt + 1) % 16);
    end
  endtask

  task automatic chk_state(input int m, input int n,
                           input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3,
                           input logic [3:0] wres, input logic [3:0] addr,
                           input logic st_x, input logic st_d, input logic st_f,
                           input logic vfd, input logic vde,
                           input logic [3:0] wbres, input logic [31:0] dout);
    string p;
    logic  exp_stall;
    p = $sformatf("dut%0d edge%0d", m, n);
    exp_stall = (n >= 1) && !m_issue[m][n+1];
    chk({p, " r0"}, r0, m_reg[m][n][0]);
    chk({p, " r1"}, r1, m_reg[m][n][1]);
    chk({p, " r2"}, r2, m_reg[m][n][2]);
    chk({p, " r3"}, r3, m_reg[m][n][3]);
    chk({p, " w_reserve"}, 32'(wres), 32'(m_wres[m][n]));
    chk({p, " addr"}, 32'(addr), 32'(m_addr[m][n]));
    chk({p, " stall_exec_insndec"}, 32'(st_x), 32'(exp_stall));
    chk({p, " stall_insndec_insnfetch"}, 32'(st_d), 32'(exp_stall));
    chk({p, " stall_insnfetch"}, 32'(st_f), 32'(exp_stall));
    chk({p, " valid_insnfetch_insndec"}, 32'(vfd), (n >= 1) ? 32'd1 : 32'd0);
    chk({p, " valid_insndec_exec"}, 32'(vde), 32'(m_issue[m][n]));
    chk({p, " wb_reserved"}, 32'(wbres), 32'(m_wres[m][n]));
    if (m_wres[m][n] != 4'd0) chk({p, " data_o"}, dout, m_val[m][n]);
  endtask

  task automatic sample(input int n);
    chk_state(0, n, dut.register.r0.data, dut.register.r1.data, dut.register.r2.data,
              dut.register.r3.data, dut.register.w_reserve, dut.insnfetch.addr,
              dut.stall_exec_insndec, dut.stall_insndec_insnfetch, dut.stall_insnfetch,
              dut.valid_insnfetch_insndec, dut.valid_insndec_exec, dut.wb_reserved, dut.register.wb_r);
    chk_state(1, n, dut2.register.r0.data, dut2.register.r1.data, dut2.register.r2.data,
              dut2.register.r3.data, dut2.register.w_reserve, dut2.insnfetch.addr,
              dut2.stall_exec_insndec, dut2.stall_insndec_insnfetch, dut2.stall_insnfetch,
              dut2.valid_insnfetch_insndec, dut2.valid_insndec_exec, dut2.wb_reserved, dut2.register.wb_r);
  endtask

  task automatic run_seg(input int first, input int last);
    for (int n = first; n <= last; n++) begin
      @(posedge clk);
      @(negedge clk);
      sample(n);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " addr"},     32'(dut.insnfetch.addr), 32'd0);
    chk({tag, " vfd"},      32'(dut.valid_insnfetch_insndec), 32'd0);
    chk({tag, " vde"},      32'(dut.valid_insndec_exec), 32'd0);
    chk({tag, " wres"},     32'(dut.register.w_reserve), 32'd0);
    chk({tag, " r0"},       dut.register.r0.data, 32'd0);
    chk({tag, " r1"},       dut.register.r1.data, 32'd0);
    chk({tag, " dec"},      dut.dec_insn_q, 32'd0);
    chk({tag, " ex_op"},    32'(dut.ex_op_q), 32'd0);
    chk({tag, " b addr"},   32'(dut2.insnfetch.addr), 32'd0);
    chk({tag, " b wres"},   32'(dut2.register.w_reserve), 32'd0);
    chk({tag, " b r2"},     dut2.register.r2.data, 32'd0);
    chk({tag, " b r3"},     dut2.register.r3.data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] p2;
    int len;
    p2 = PROG2;
    for (int i = 0; i < 16; i++) begin
      prog[0][i] = 32'h0;
      prog[1][i] = p2[i*32 +: 32];
    end
    prog[0][0] = 32'h1000_0001;
    prog[0][1] = 32'h1400_0002;
    prog[0][2] = 32'h2100_0000;
    prog[0][3] = 32'h2400_0000;
    build_model(0);
    build_model(1);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(0);
    chk("insn at addr0", dut.insn, 32'h1000_0001);
    chk("insn at addr0 image", dut2.insn, 32'h1800_FFFF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample(1);
    chk("decode latch edge1", dut.dec_insn_q, 32'h1000_0001);
    len = $urandom_range(40, 90);
    run_seg(2, len);

    for (int seg = 0; seg < 3; seg++) begin
      #($urandom_range(1, 3));
      rst = 1'b0;
      #1;
      chk_cleared($sformatf("async reset %0d", seg));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      sample(0);
      rst = 1'b1;
      len = $urandom_range(20, 90);
      run_seg(1, len);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
